// File: rtl/coder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coder_pkg
// Description : Shared constants for the coder_scan block: the hex-to-segment
//               lookup table (common-anode, active-low {g,f,e,d,c,b,a}), the
//               blank pattern and a clog2 helper that never returns zero.
// Revision    : 1.0 - initial release
// ============================================================================
package coder_pkg;

    // All segments off on a common-anode display.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index is the nibble value 0..F; the glyphs for b and d are lower case.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Width needed to hold values 0..n-1, never less than one bit so that
    // degenerate configurations still produce legal vectors.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : coder_pkg
`default_nettype wire

// File: rtl/seg_hex7.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex7
// Description : Combinational 4-bit value to 7-segment pattern lookup.
// Ports       : nib [3:0] in  - hex digit value
//               seg [6:0] out - segments {g,f,e,d,c,b,a}, active-low
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex7
    import coder_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule : seg_hex7
`default_nettype wire

// File: rtl/coder_scan.sv
`default_nettype none
// ============================================================================
// Module      : coder_scan
// Description : Priority / strict one-hot encoder with registered outputs, a
//               DIGITS-deep history of captured codes that is time-multiplexed
//               onto a common-anode 7-segment display, and a registered
//               one-hot decoder.
// Ports       : clk, rst_n (async, active-low)
//               e, p, x[N_IN]  - encoder enable, mode (1=priority), input
//               ld, clr        - capture strobe, synchronous history clear
//               a[CW]          - decoder select
//               f, err, d[CW]  - registered encoder valid / error / code
//               y[N_IN]        - registered one-hot decode of a
//               cn[7], an[DIGITS] - active-low segments and anodes
//               dp             - active-low decimal point (CODER_DP_EN only)
// Options     : CODER_DP_EN - adds dp, lit on digit 0 when history is non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module coder_scan
    import coder_pkg::*;
#(
    parameter  int N_IN     = 10,
    parameter  int DIGITS   = 8,
    parameter  int SCAN_DIV = 100000,
    localparam int CW       = clog2_min1(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              e,
    input  logic              p,
    input  logic [N_IN-1:0]   x,
    input  logic              ld,
    input  logic              clr,
    input  logic [CW-1:0]     a,
    output logic              f,
    output logic              err,
    output logic [CW-1:0]     d,
    output logic [N_IN-1:0]   y,
    output logic [6:0]        cn,
    output logic [DIGITS-1:0] an
`ifdef CODER_DP_EN
    ,
    output logic              dp
`endif
);

    localparam int IDXW = clog2_min1(DIGITS);
    localparam int CNTW = clog2_min1(DIGITS + 1);
    localparam int DIVW = clog2_min1(SCAN_DIV);

    localparam logic [N_IN-1:0] X_ONE = {{(N_IN-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Encoder / decoder
    // ------------------------------------------------------------------
    logic [CW-1:0]   d_d, d_q, pri_idx;
    logic            f_d, f_q, err_d, err_q, onehot;
    logic [N_IN-1:0] y_d, y_q;

    always_comb begin
        pri_idx = '0;
        // Later iterations overwrite earlier ones, so the highest set bit wins.
        for (int i = 0; i < N_IN; i++) begin
            if (x[i]) pri_idx = CW'(i);
        end
        onehot = (x != '0) && ((x & (x - X_ONE)) == '0);

        d_d   = '0;
        f_d   = 1'b0;
        err_d = 1'b0;
        if (e) begin
            if (p) begin
                d_d = pri_idx;
                f_d = |x;
            end else if (onehot) begin
                d_d = pri_idx;
                f_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end

        y_d = '0;
        if (int'(a) < N_IN) y_d[a] = 1'b1;
    end

    // ------------------------------------------------------------------
    // History shift register; entry 0 is always the newest capture
    // ------------------------------------------------------------------
    logic [CW-1:0]   hist_d [DIGITS];
    logic [CW-1:0]   hist_q [DIGITS];
    logic [CNTW-1:0] count_d, count_q;

    always_comb begin
        hist_d  = hist_q;
        count_d = count_q;
        if (clr) begin
            for (int i = 0; i < DIGITS; i++) hist_d[i] = '0;
            count_d = '0;
        end else if (ld && f_d) begin
            // Capture uses the code being registered this cycle, so an
            // invalid input on the strobe cycle is simply not recorded.
            for (int i = DIGITS - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
            hist_d[0] = d_d;
            if (count_q != CNTW'(DIGITS)) count_d = count_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Scanner: divider, digit index and registered anode/segment drive
    // ------------------------------------------------------------------
    logic [DIVW-1:0]   div_d, div_q;
    logic [IDXW-1:0]   idx_d, idx_q;
    logic [DIGITS-1:0] an_d, an_q;
    logic [6:0]        cn_d, cn_q, seg_w;
    logic [3:0]        nib_w;
    logic              div_wrap;

    assign nib_w = 4'(hist_q[idx_q]);

    seg_hex7 u_seg_hex7 (
        .nib (nib_w),
        .seg (seg_w)
    );

    always_comb begin
        div_wrap = (div_q == DIVW'(SCAN_DIV - 1));
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        idx_d    = idx_q;
        if (div_wrap) begin
            idx_d = (idx_q == IDXW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // Registered from the current index, so the display trails idx by
        // one cycle.
        an_d = ~(DIGITS'(1) << idx_q);
        cn_d = (CNTW'(idx_q) < count_q) ? seg_w : SEG_BLANK;
    end

`ifdef CODER_DP_EN
    logic dp_d, dp_q;

    assign dp_d = !((idx_q == '0) && (count_q != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dp_q <= 1'b1;
        else        dp_q <= dp_d;
    end

    assign dp = dp_q;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            f_q     <= 1'b0;
            err_q   <= 1'b0;
            y_q     <= '0;
            count_q <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            cn_q    <= SEG_BLANK;
            for (int i = 0; i < DIGITS; i++) hist_q[i] <= '0;
        end else begin
            d_q     <= d_d;
            f_q     <= f_d;
            err_q   <= err_d;
            y_q     <= y_d;
            count_q <= count_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            cn_q    <= cn_d;
            for (int i = 0; i < DIGITS; i++) hist_q[i] <= hist_d[i];
        end
    end

    assign d   = d_q;
    assign f   = f_q;
    assign err = err_q;
    assign y   = y_q;
    assign an  = an_q;
    assign cn  = cn_q;

endmodule : coder_scan
`default_nettype wire

// File: tb/tb_coder_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_coder_scan
// Description : Directed self-checking bench for coder_scan (N_IN=10,
//               DIGITS=8, SCAN_DIV=4). Encoder/decoder expectations go
//               through scoreboard queues; display expectations come from a
//               model of the capture history and an independent hex table.
//               Handles the CODER_DP_EN build as well.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coder_scan;

    localparam int N_IN     = 10;
    localparam int DIGITS   = 8;
    localparam int SCAN_DIV = 4;
    localparam int CW       = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              e, p, ld, clr;
    logic [N_IN-1:0]   x;
    logic [CW-1:0]     a;
    logic              f, err;
    logic [CW-1:0]     d;
    logic [N_IN-1:0]   y;
    logic [6:0]        cn;
    logic [DIGITS-1:0] an;
`ifdef CODER_DP_EN
    logic              dp;
`endif

    coder_scan #(.N_IN(N_IN), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .e     (e),
        .p     (p),
        .x     (x),
        .ld    (ld),
        .clr   (clr),
        .a     (a),
        .f     (f),
        .err   (err),
        .d     (d),
        .y     (y),
        .cn    (cn),
        .an    (an)
`ifdef CODER_DP_EN
        ,
        .dp    (dp)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [CW-1:0] d;
        logic          f;
        logic          err;
    } enc_exp_t;

    typedef struct {
        string           tag;
        logic [N_IN-1:0] y;
    } dec_exp_t;

    enc_exp_t enc_q[$];
    dec_exp_t dec_q[$];
    int       model[$];     // newest capture first

    logic [6:0] hex_tbl [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enc_step(input string tag, input logic ie, input logic ip,
                            input logic [N_IN-1:0] ix, input int ed,
                            input logic ef, input logic eerr);
        enc_exp_t ex, got;
        e = ie; p = ip; x = ix;
        ex.tag = tag; ex.d = CW'(ed); ex.f = ef; ex.err = eerr;
        enc_q.push_back(ex);
        tick();
        got = enc_q.pop_front();
        chk({got.tag, "_d"},   32'(d),   32'(got.d));
        chk({got.tag, "_f"},   32'(f),   32'(got.f));
        chk({got.tag, "_err"}, 32'(err), 32'(got.err));
    endtask

    task automatic dec_step(input string tag, input logic [CW-1:0] ia,
                            input logic [N_IN-1:0] ey);
        dec_exp_t ex, got;
        a = ia;
        ex.tag = tag; ex.y = ey;
        dec_q.push_back(ex);
        tick();
        got = dec_q.pop_front();
        chk(got.tag, 32'(y), 32'(got.y));
    endtask

    // Capture a code via a priority-mode strobe and mirror it in the model.
    task automatic load_code(input int code);
        e = 1'b1; p = 1'b1; x = N_IN'(1) << code; ld = 1'b1;
        tick();
        ld = 1'b0;
        model.push_front(code);
        if (model.size() > DIGITS) void'(model.pop_back());
    endtask

    task automatic check_digit(input int k, input string tag);
        logic [DIGITS-1:0] target;
        logic [6:0]        exp_cn;
        bit                found;
        target = ~(DIGITS'(1) << k);
        found  = 0;
        for (int n = 0; n < 4 * SCAN_DIV * DIGITS; n++) begin
            tick();
            if (an === target) begin
                found = 1;
                break;
            end
        end
        chk($sformatf("%s_an%0d_seen", tag, k), 32'(found), 32'd1);
        exp_cn = (k < model.size()) ? hex_tbl[model[k]] : 7'h7F;
        chk($sformatf("%s_cn%0d", tag, k), 32'(cn), 32'(exp_cn));
`ifdef CODER_DP_EN
        chk($sformatf("%s_dp%0d", tag, k), 32'(dp),
            32'(!(k == 0 && model.size() > 0)));
`endif
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < DIGITS; k++) check_digit(k, tag);
    endtask

    initial begin
        rst_n = 1'b0; e = 1'b0; p = 1'b0; x = '0; ld = 1'b0; clr = 1'b0; a = '0;

        // Power-on reset values
        tick(); tick(); tick();
        chk("rst_an",  32'(an),  32'hFF);
        chk("rst_cn",  32'(cn),  32'h7F);
        chk("rst_f",   32'(f),   32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_d",   32'(d),   32'd0);
        chk("rst_y",   32'(y),   32'd0);
`ifdef CODER_DP_EN
        chk("rst_dp",  32'(dp),  32'd1);
`endif

        // Reset while scanning: asynchronous return, restart at digit 0
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_an", 32'(an), 32'hFF);
        chk("midrst_cn", 32'(cn), 32'h7F);
        chk("midrst_f",  32'(f),  32'd0);
        chk("midrst_d",  32'(d),  32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("midrst_first_an", 32'(an), 32'hFE);

        // Priority encode 0x14 -> 4, then capture it
        enc_step("pri14", 1'b1, 1'b1, 10'b0000010100, 4, 1'b1, 1'b0);
        ld = 1'b1;
        tick();
        ld = 1'b0;
        model.push_front(4);
        check_all("ld4");

        // Clear, then an invalid one-hot capture must be ignored
        clr = 1'b1;
        tick();
        clr = 1'b0;
        model.delete();
        enc_step("oh14", 1'b1, 1'b0, 10'b0000010100, 0, 1'b0, 1'b1);
        ld = 1'b1;
        tick();
        ld = 1'b0;
        check_all("ldbad");

        // Other encoder corners
        enc_step("dis",   1'b0, 1'b1, 10'b0000010100, 0, 1'b0, 1'b0);
        enc_step("pri0",  1'b1, 1'b1, 10'b0000000000, 0, 1'b0, 1'b0);
        enc_step("oh9",   1'b1, 1'b0, 10'b1000000000, 9, 1'b1, 1'b0);
        enc_step("oh0",   1'b1, 1'b0, 10'b0000000000, 0, 1'b0, 1'b1);
        enc_step("priall",1'b1, 1'b1, 10'b1111111111, 9, 1'b1, 1'b0);
        enc_step("oh_b0", 1'b1, 1'b0, 10'b0000000001, 0, 1'b1, 1'b0);

        // History ordering and saturation
        load_code(1);
        load_code(2);
        load_code(3);
        for (int k = 0; k < 4; k++) check_digit(k, "seq3");
        for (int c = 4; c < 13; c++) load_code(c % 10);
        check_all("sat");

        // Decoder
        dec_step("dec3",  4'b0011, 10'b0000001000);
        dec_step("dec12", 4'b1100, 10'b0000000000);
        dec_step("dec9",  4'b1001, 10'b1000000000);
        dec_step("dec10", 4'b1010, 10'b0000000000);
        dec_step("dec0",  4'b0000, 10'b0000000001);

        // ld and clr together: clear wins
        e = 1'b1; p = 1'b1; x = 10'b0000100000; ld = 1'b1; clr = 1'b1;
        tick();
        ld = 1'b0; clr = 1'b0;
        model.delete();
        check_all("ldclr");
        load_code(6);
        check_digit(0, "after_clr");
        check_digit(1, "after_clr");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_coder_scan
`default_nettype wire
